// File: rtl/z80_stack_seq_if.sv
// Byte-wide memory bus between the stack sequencer (master) and the memory
// bus interface (slave).
//
// Handshake: the master raises bus_req with bus_we/bus_addr/bus_wdata and
// holds all four stable until it samples bus_ack = 1 on a rising clock edge;
// that edge completes the byte cycle. bus_rdata is only meaningful while
// bus_ack = 1, and bus_ack is ignored whenever bus_req = 0.
interface z80_stack_seq_if;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/z80_stack_seq.sv
// Z80 stack transfer sequencer.
//
// Turns one 16-bit PUSH/CALL/RST push or POP/RET pop into two byte bus
// cycles and reports the new SP. Two requesters compete for it: the
// instruction datapath (push or pop) and interrupt acknowledge (PC push).
//
// Requester handshake: a requester holds *_valid and its payload until it
// sees *_ready = 1 in the same cycle; that rising edge is the accept. Readies
// are combinational and only ever high in IDLE, so at most one request is in
// flight and a losing requester simply keeps its valid asserted.
//
// Push order follows PUSH qq: high byte to SP-1, then low byte to SP-2.
// Pop reads the low byte from SP, then the high byte from SP+1.
// All address arithmetic wraps modulo 2^16.
module z80_stack_seq #(
    parameter int IRQ_FIRST   = 1,  // 1: interrupt wins a tie, 0: instruction wins
    parameter int BUS_TIMEOUT = 0   // max cycles per byte waiting for ack, 0 = no limit
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [15:0] sp_in,

    input  logic        ins_valid,
    output logic        ins_ready,
    input  logic        ins_pop,
    input  logic [15:0] ins_wdata,

    input  logic        irq_valid,
    output logic        irq_ready,
    input  logic [15:0] irq_wdata,

    z80_stack_seq_if.master bus,

    output logic        done,
    output logic        done_irq,
    output logic [15:0] pop_data,
    output logic        sp_we,
    output logic [15:0] sp_out,
    output logic        err,

    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BYTE1 = 2'd1,
        S_BYTE2 = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // Wait counter only needs to reach BUS_TIMEOUT-1.
    localparam int TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;

    // Transfer context latched at accept.
    logic          op_pop_q;
    logic          src_irq_q;
    logic [15:0]   data_q;      // push payload; low byte reused as pop staging
    logic [15:0]   base_q;      // SP at accept
    logic [15:0]   pop_data_q;

    // Arbitration and per-cycle control strobes.
    logic          irq_win;
    logic          ins_win;
    logic          accept;
    logic          cap_lo;
    logic          cap_hi;
    logic          to_hit;
    logic [TW-1:0] tcnt_inc;

    // Tie-break between the two requesters; a lone valid always wins.
    assign irq_win = irq_valid && (!ins_valid || (IRQ_FIRST != 0));
    assign ins_win = ins_valid && !irq_win;

    // Timeout fires on the last allowed wait cycle of a byte state.
    assign to_hit   = (BUS_TIMEOUT > 0) && (tcnt_q == TO_LAST);
    assign tcnt_inc = (BUS_TIMEOUT > 0) ? tcnt_q + TW'(1) : '0;

    // Next-state, bus drive and completion outputs.
    always_comb begin
        state_d       = state_q;
        tcnt_d        = '0;
        err_d         = 1'b0;
        ins_ready     = 1'b0;
        irq_ready     = 1'b0;
        accept        = 1'b0;
        cap_lo        = 1'b0;
        cap_hi        = 1'b0;
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = 16'h0000;
        bus.bus_wdata = 8'h00;
        done          = 1'b0;
        sp_we         = 1'b0;
        done_irq      = 1'b0;
        sp_out        = 16'h0000;

        case (state_q)
            S_IDLE: begin
                irq_ready = irq_win;
                ins_ready = ins_win;
                accept    = irq_win || ins_win;
                if (accept) begin
                    state_d = S_BYTE1;
                end
            end

            S_BYTE1: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = !op_pop_q;
                bus.bus_addr  = op_pop_q ? base_q : base_q - 16'd1;
                bus.bus_wdata = op_pop_q ? 8'h00 : data_q[15:8];
                if (bus.bus_ack) begin
                    state_d = S_BYTE2;
                    cap_lo  = op_pop_q;
                end else if (to_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end

            S_BYTE2: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = !op_pop_q;
                bus.bus_addr  = op_pop_q ? base_q + 16'd1 : base_q - 16'd2;
                bus.bus_wdata = op_pop_q ? 8'h00 : data_q[7:0];
                if (bus.bus_ack) begin
                    state_d = S_FIN;
                    cap_hi  = op_pop_q;
                end else if (to_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end

            S_FIN: begin
                done     = 1'b1;
                sp_we    = 1'b1;
                done_irq = src_irq_q;
                sp_out   = op_pop_q ? base_q + 16'd2 : base_q - 16'd2;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, per-byte wait counter and the registered err pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

    // Latch transfer context at accept and assemble pop bytes as they arrive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_pop_q   <= 1'b0;
            src_irq_q  <= 1'b0;
            data_q     <= 16'h0000;
            base_q     <= 16'h0000;
            pop_data_q <= 16'h0000;
        end else begin
            if (accept) begin
                op_pop_q  <= irq_win ? 1'b0 : ins_pop;
                src_irq_q <= irq_win;
                data_q    <= irq_win ? irq_wdata : ins_wdata;
                base_q    <= sp_in;
            end
            if (cap_lo) begin
                data_q[7:0] <= bus.bus_rdata;
            end
            // Result becomes visible in FIN and is held until the next pop.
            if (cap_hi) begin
                pop_data_q <= {bus.bus_rdata, data_q[7:0]};
            end
        end
    end

    assign pop_data  = pop_data_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_z80_stack_seq.sv
// Bench for z80_stack_seq: directed scenarios plus randomized push/pop traffic
// checked against a byte-addressed stack memory model.
module tb_z80_stack_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [15:0] sp_in = 16'h0000;
    logic        ins_valid = 1'b0;
    logic        ins_pop = 1'b0;
    logic [15:0] ins_wdata = 16'h0000;
    logic        irq_valid = 1'b0;
    logic [15:0] irq_wdata = 16'h0000;
    logic        ins_ready, irq_ready;
    logic        done, done_irq, sp_we, err;
    logic [15:0] pop_data, sp_out;
    logic [1:0]  dbg_state;

    z80_stack_seq_if bus_if ();

    z80_stack_seq #(.IRQ_FIRST(1), .BUS_TIMEOUT(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sp_in     (sp_in),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_pop   (ins_pop),
        .ins_wdata (ins_wdata),
        .irq_valid (irq_valid),
        .irq_ready (irq_ready),
        .irq_wdata (irq_wdata),
        .bus       (bus_if),
        .done      (done),
        .done_irq  (done_irq),
        .pop_data  (pop_data),
        .sp_we     (sp_we),
        .sp_out    (sp_out),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [24:0] exp_q[$];          // {we, addr, byte}
    logic [24:0] act_q[$];
    logic [7:0]  ref_mem [logic [15:0]];
    logic [15:0] ref_pop = 16'h0000;

    // ---------------- memory responder ----------------
    logic [7:0]  resp_mem [logic [15:0]];
    int          wait_q[$];         // wait cycles per byte, consumed in order
    bit          ack_en = 1'b1;
    bit          in_byte = 1'b0;
    int          wait_left = 0;
    logic [24:0] byte_sig;
    int          stab_err = 0;

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    // Answers byte cycles after the programmed wait and logs every completed byte.
    always @(negedge clk) begin
        if (!ack_en || bus_if.bus_req !== 1'b1) begin
            bus_if.bus_ack = 1'b0;
            in_byte = 1'b0;
        end else begin
            if (!in_byte) begin
                in_byte = 1'b1;
                wait_left = 0;
                if (wait_q.size() > 0) wait_left = wait_q.pop_front();
                byte_sig = {bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata};
            end else if ({bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata} !== byte_sig) begin
                stab_err++;
            end
            if (wait_left > 0) begin
                wait_left--;
                bus_if.bus_ack = 1'b0;
            end else begin
                bus_if.bus_ack = 1'b1;
                in_byte = 1'b0;
                if (bus_if.bus_we) begin
                    resp_mem[bus_if.bus_addr] = bus_if.bus_wdata;
                    act_q.push_back({1'b1, bus_if.bus_addr, bus_if.bus_wdata});
                end else begin
                    bus_if.bus_rdata = resp_mem.exists(bus_if.bus_addr) ?
                                       resp_mem[bus_if.bus_addr] : dflt(bus_if.bus_addr);
                    act_q.push_back({1'b0, bus_if.bus_addr, bus_if.bus_rdata});
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one request, waits for accept then for done; reports latency from accept.
    task automatic drive_req(input bit src_irq, input bit pop, input logic [15:0] sp,
                             input logic [15:0] data, output int lat, output logic [15:0] o_sp,
                             output logic o_irq, output logic o_spwe, output bit got);
        int t0;
        got = 1'b0; lat = -1; o_sp = 'x; o_irq = 'x; o_spwe = 'x;
        @(negedge clk);
        sp_in = sp;
        if (src_irq) begin
            irq_valid = 1'b1; irq_wdata = data;
        end else begin
            ins_valid = 1'b1; ins_pop = pop; ins_wdata = data;
        end
        #1;
        for (int i = 0; i < 20; i++) begin
            if ((src_irq ? irq_ready : ins_ready) === 1'b1) break;
            @(negedge clk); #1;
        end
        t0 = cyc;
        @(negedge clk);
        ins_valid = 1'b0; irq_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (done === 1'b1) begin
                got = 1'b1; lat = cyc - t0; o_sp = sp_out; o_irq = done_irq; o_spwe = sp_we;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL reset_bus_req: got %b expected 0", bus_if.bus_req); end
        n_checks++; if ({done, sp_we, err, done_irq} !== 4'b0) begin n_errors++; $display("FAIL reset_strobes: got %b expected 0000", {done, sp_we, err, done_irq}); end
        n_checks++; if (pop_data !== 16'h0000) begin n_errors++; $display("FAIL reset_pop_data: got %h expected 0000", pop_data); end
        n_checks++; if (sp_out !== 16'h0000) begin n_errors++; $display("FAIL reset_sp_out: got %h expected 0000", sp_out); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_push_zero_wait();
        int lat; logic [15:0] o_sp; logic o_irq, o_spwe; bit got;
        wait_q.delete(); act_q.delete(); exp_q.delete();
        exp_q.push_back({1'b1, 16'h7FFF, 8'h12});
        exp_q.push_back({1'b1, 16'h7FFE, 8'h34});
        drive_req(1'b0, 1'b0, 16'h8000, 16'h1234, lat, o_sp, o_irq, o_spwe, got);
        n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL push_done_seen: got %b expected 1", got); end
        n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL push_latency: got %0d expected 3", lat); end
        n_checks++; if (o_sp !== 16'h7FFE) begin n_errors++; $display("FAIL push_sp_out: got %h expected 7ffe", o_sp); end
        n_checks++; if ({o_spwe, o_irq} !== 2'b10) begin n_errors++; $display("FAIL push_sp_we_irq: got %b expected 10", {o_spwe, o_irq}); end
        while (exp_q.size() > 0) begin
            logic [24:0] e, a;
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++; if (a !== e) begin n_errors++; $display("FAIL push_bus: got %h expected %h", a, e); end
        end
        n_checks++; if (act_q.size() !== 0) begin n_errors++; $display("FAIL push_bus_extra: got %0d expected 0", act_q.size()); end
    endtask

    task automatic test_pop_waits();
        int lat; logic [15:0] o_sp; logic o_irq, o_spwe; bit got;
        wait_q.delete(); act_q.delete(); exp_q.delete();
        resp_mem[16'h7FFE] = 8'h34;
        resp_mem[16'h7FFF] = 8'h12;
        stab_err = 0;
        wait_q.push_back(2); wait_q.push_back(2);
        exp_q.push_back({1'b0, 16'h7FFE, 8'h34});
        exp_q.push_back({1'b0, 16'h7FFF, 8'h12});
        drive_req(1'b0, 1'b1, 16'h7FFE, 16'h0000, lat, o_sp, o_irq, o_spwe, got);
        n_checks++; if (lat !== 7) begin n_errors++; $display("FAIL pop_latency: got %0d expected 7", lat); end
        n_checks++; if (o_sp !== 16'h8000) begin n_errors++; $display("FAIL pop_sp_out: got %h expected 8000", o_sp); end
        n_checks++; if (pop_data !== 16'h1234) begin n_errors++; $display("FAIL pop_data: got %h expected 1234", pop_data); end
        n_checks++; if (stab_err !== 0) begin n_errors++; $display("FAIL pop_bus_stable: got %0d changes expected 0", stab_err); end
        while (exp_q.size() > 0) begin
            logic [24:0] e, a;
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++; if (a !== e) begin n_errors++; $display("FAIL pop_bus: got %h expected %h", a, e); end
        end
        ref_pop = 16'h1234;
    endtask

    task automatic test_wrap();
        int lat; logic [15:0] o_sp; logic o_irq, o_spwe; bit got;
        wait_q.delete(); act_q.delete(); exp_q.delete();
        exp_q.push_back({1'b1, 16'h0000, 8'hBE});
        exp_q.push_back({1'b1, 16'hFFFF, 8'hEF});
        exp_q.push_back({1'b0, 16'hFFFF, 8'hEF});
        exp_q.push_back({1'b0, 16'h0000, 8'hBE});
        drive_req(1'b0, 1'b0, 16'h0001, 16'hBEEF, lat, o_sp, o_irq, o_spwe, got);
        n_checks++; if (o_sp !== 16'hFFFF) begin n_errors++; $display("FAIL wrap_push_sp: got %h expected ffff", o_sp); end
        drive_req(1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, o_sp, o_irq, o_spwe, got);
        n_checks++; if (o_sp !== 16'h0001) begin n_errors++; $display("FAIL wrap_pop_sp: got %h expected 0001", o_sp); end
        n_checks++; if (pop_data !== 16'hBEEF) begin n_errors++; $display("FAIL wrap_pop_data: got %h expected beef", pop_data); end
        while (exp_q.size() > 0) begin
            logic [24:0] e, a;
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++; if (a !== e) begin n_errors++; $display("FAIL wrap_bus: got %h expected %h", a, e); end
        end
        ref_pop = 16'hBEEF;
    endtask

    task automatic test_arbitration();
        int t0, viol, lat1, lat2; bit seen1, seen2;
        logic [15:0] sp1, sp2; logic irq1, irq2;
        wait_q.delete(); act_q.delete(); exp_q.delete();
        exp_q.push_back({1'b1, 16'h8FFF, 8'hAB});
        exp_q.push_back({1'b1, 16'h8FFE, 8'hCD});
        exp_q.push_back({1'b1, 16'h8FFD, 8'h55});
        exp_q.push_back({1'b1, 16'h8FFC, 8'hAA});
        @(negedge clk);
        sp_in = 16'h9000; irq_wdata = 16'hABCD;
        ins_pop = 1'b0; ins_wdata = 16'h55AA;
        irq_valid = 1'b1; ins_valid = 1'b1;
        #1;
        n_checks++; if ({irq_ready, ins_ready} !== 2'b10) begin n_errors++; $display("FAIL arb_tie_readies: got %b expected 10", {irq_ready, ins_ready}); end
        t0 = cyc;
        @(negedge clk);
        irq_valid = 1'b0;
        viol = 0; seen1 = 1'b0; lat1 = -1; sp1 = 'x; irq1 = 'x;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ins_ready !== 1'b0) viol++;
            if (done === 1'b1) begin seen1 = 1'b1; lat1 = cyc - t0; sp1 = sp_out; irq1 = done_irq; break; end
            @(negedge clk);
        end
        n_checks++; if (seen1 !== 1'b1 || lat1 !== 3) begin n_errors++; $display("FAIL arb_irq_latency: got %0d expected 3", lat1); end
        n_checks++; if (irq1 !== 1'b1) begin n_errors++; $display("FAIL arb_done_irq: got %b expected 1", irq1); end
        n_checks++; if (sp1 !== 16'h8FFE) begin n_errors++; $display("FAIL arb_irq_sp: got %h expected 8ffe", sp1); end
        n_checks++; if (viol !== 0) begin n_errors++; $display("FAIL arb_ins_held_off: got %0d ready cycles expected 0", viol); end
        sp_in = 16'h8FFE;
        @(negedge clk); #1;
        n_checks++; if ({irq_ready, ins_ready} !== 2'b01) begin n_errors++; $display("FAIL arb_ins_next_idle: got %b expected 01", {irq_ready, ins_ready}); end
        t0 = cyc;
        @(negedge clk);
        ins_valid = 1'b0;
        seen2 = 1'b0; lat2 = -1; sp2 = 'x; irq2 = 'x;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (done === 1'b1) begin seen2 = 1'b1; lat2 = cyc - t0; sp2 = sp_out; irq2 = done_irq; break; end
            @(negedge clk);
        end
        n_checks++; if (seen2 !== 1'b1 || lat2 !== 3) begin n_errors++; $display("FAIL arb_ins_latency: got %0d expected 3", lat2); end
        n_checks++; if ({irq2, sp2} !== {1'b0, 16'h8FFC}) begin n_errors++; $display("FAIL arb_ins_result: got %b/%h expected 0/8ffc", irq2, sp2); end
        while (exp_q.size() > 0) begin
            logic [24:0] e, a;
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++; if (a !== e) begin n_errors++; $display("FAIL arb_bus: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_timeout();
        int t0, req_cycles, err_cycles, err_at, strobes; logic [15:0] first_addr;
        wait_q.delete(); act_q.delete();
        ack_en = 1'b0;
        @(negedge clk);
        sp_in = 16'h4000; ins_pop = 1'b0; ins_wdata = 16'h1111; ins_valid = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (ins_ready === 1'b1) break;
            @(negedge clk); #1;
        end
        t0 = cyc;
        @(negedge clk);
        ins_valid = 1'b0;
        req_cycles = 0; err_cycles = 0; err_at = -1; strobes = 0; first_addr = 'x;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus_if.bus_req === 1'b1) begin
                if (req_cycles == 0) first_addr = bus_if.bus_addr;
                req_cycles++;
            end
            if (err === 1'b1) begin
                if (err_cycles == 0) err_at = cyc - t0;
                err_cycles++;
            end
            if (done === 1'b1 || sp_we === 1'b1) strobes++;
            @(negedge clk);
        end
        #1;
        n_checks++; if (req_cycles !== 4) begin n_errors++; $display("FAIL timeout_req_cycles: got %0d expected 4", req_cycles); end
        n_checks++; if (first_addr !== 16'h3FFF) begin n_errors++; $display("FAIL timeout_addr: got %h expected 3fff", first_addr); end
        n_checks++; if (err_cycles !== 1 || err_at !== 5) begin n_errors++; $display("FAIL timeout_err_pulse: got %0d cycles at +%0d expected 1 at +5", err_cycles, err_at); end
        n_checks++; if (strobes !== 0) begin n_errors++; $display("FAIL timeout_no_done: got %0d strobes expected 0", strobes); end
        n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL timeout_idle: got %0d expected 0", dbg_state); end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid_xfer();
        int lat, strobes; logic [15:0] o_sp; logic o_irq, o_spwe; bit got, in_b2;
        wait_q.delete(); act_q.delete(); exp_q.delete();
        wait_q.push_back(0); wait_q.push_back(3);
        @(negedge clk);
        sp_in = 16'h6000; ins_pop = 1'b0; ins_wdata = 16'hCAFE; ins_valid = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (ins_ready === 1'b1) break;
            @(negedge clk); #1;
        end
        @(negedge clk);
        ins_valid = 1'b0;
        in_b2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (dbg_state === 2'd2) begin in_b2 = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (in_b2 !== 1'b1) begin n_errors++; $display("FAIL rst_mid_reach_byte2: got %b expected 1", in_b2); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL rst_mid_bus_req: got %b expected 0", bus_if.bus_req); end
        n_checks++; if (pop_data !== 16'h0000) begin n_errors++; $display("FAIL rst_mid_pop_data: got %h expected 0000", pop_data); end
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1 || sp_we === 1'b1) strobes++;
        end
        n_checks++; if (strobes !== 0) begin n_errors++; $display("FAIL rst_mid_no_done: got %0d strobes expected 0", strobes); end
        @(negedge clk);
        reset_n = 1'b1;
        ref_pop = 16'h0000;
        wait_q.delete(); act_q.delete();
        exp_q.push_back({1'b1, 16'h7FFF, 8'h12});
        exp_q.push_back({1'b1, 16'h7FFE, 8'h34});
        drive_req(1'b0, 1'b0, 16'h8000, 16'h1234, lat, o_sp, o_irq, o_spwe, got);
        n_checks++; if (lat !== 3 || o_sp !== 16'h7FFE) begin n_errors++; $display("FAIL rst_mid_repush: got lat %0d sp %h expected lat 3 sp 7ffe", lat, o_sp); end
        while (exp_q.size() > 0) begin
            logic [24:0] e, a;
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            n_checks++; if (a !== e) begin n_errors++; $display("FAIL rst_mid_bus: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_random();
        ref_mem = resp_mem;
        stab_err = 0;
        for (int it = 0; it < 40; it++) begin
            bit si, po, got; int w1, w2, lat;
            logic [15:0] sp, d, o_sp, exp_sp; logic o_irq, o_spwe;
            si = ($urandom_range(0, 3) == 0);
            po = si ? 1'b0 : 1'($urandom_range(0, 1));
            sp = 16'($urandom_range(0, 65535));
            d  = 16'($urandom_range(0, 65535));
            if (it % 8 == 0) sp = 16'h0000;
            if (it % 8 == 4) sp = 16'hFFFF;
            w1 = $urandom_range(0, 3);
            w2 = $urandom_range(0, 3);
            wait_q.delete(); act_q.delete(); exp_q.delete();
            wait_q.push_back(w1); wait_q.push_back(w2);
            if (po) begin
                exp_q.push_back({1'b0, sp, ref_rd(sp)});
                exp_q.push_back({1'b0, sp + 16'd1, ref_rd(sp + 16'd1)});
                ref_pop = {ref_rd(sp + 16'd1), ref_rd(sp)};
                exp_sp = sp + 16'd2;
            end else begin
                exp_q.push_back({1'b1, sp - 16'd1, d[15:8]});
                exp_q.push_back({1'b1, sp - 16'd2, d[7:0]});
                ref_mem[sp - 16'd1] = d[15:8];
                ref_mem[sp - 16'd2] = d[7:0];
                exp_sp = sp - 16'd2;
            end
            drive_req(si, po, sp, d, lat, o_sp, o_irq, o_spwe, got);
            n_checks++; if (lat !== 3 + w1 + w2) begin n_errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", it, lat, 3 + w1 + w2); end
            n_checks++; if (o_sp !== exp_sp) begin n_errors++; $display("FAIL rnd_sp_out[%0d]: got %h expected %h", it, o_sp, exp_sp); end
            n_checks++; if ({o_spwe, o_irq} !== {1'b1, si}) begin n_errors++; $display("FAIL rnd_sp_we_irq[%0d]: got %b expected %b", it, {o_spwe, o_irq}, {1'b1, si}); end
            n_checks++; if (pop_data !== ref_pop) begin n_errors++; $display("FAIL rnd_pop_data[%0d]: got %h expected %h", it, pop_data, ref_pop); end
            while (exp_q.size() > 0) begin
                logic [24:0] e, a;
                e = exp_q.pop_front();
                a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
                n_checks++; if (a !== e) begin n_errors++; $display("FAIL rnd_bus[%0d]: got %h expected %h", it, a, e); end
            end
        end
        n_checks++; if (stab_err !== 0) begin n_errors++; $display("FAIL rnd_bus_stable: got %0d changes expected 0", stab_err); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_push_zero_wait();
        test_pop_waits();
        test_wrap();
        test_arbitration();
        test_timeout();
        test_reset_mid_xfer();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard bound on simulated time.
    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish before 300000");
        $fatal(1, "watchdog expired");
    end

endmodule
